// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED controller: register map, per-LED mode
// encoding and small helpers used by the top level.
package led_ctrl_pkg;

    // Register byte addresses (bits [1:0] are never decoded)
    localparam logic [3:0] ADDR_MODE     = 4'h0;
    localparam logic [3:0] ADDR_TICK_DIV = 4'h4;
    localparam logic [3:0] ADDR_BLINK    = 4'h8;
    localparam logic [3:0] ADDR_STATUS   = 4'hC;

    // Number of LEDs owned by the controller
    localparam int unsigned NUM_LEDS = 3;

    // Per-LED source selection, 2 bits each in the MODE register
    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_BLINK = 2'd2,
        LED_EVT   = 2'd3
    } led_mode_e;

    // Terminal value of the blink counter; a half-period of 0 acts as 1
    function automatic logic [7:0] blink_last(input logic [7:0] half);
        logic [7:0] last;
        if (half == 8'd0) begin
            last = 8'd0;
        end else begin
            last = half - 8'd1;
        end
        return last;
    endfunction

    // Selects what one LED shows for a given mode
    function automatic logic led_drive(input led_mode_e mode,
                                       input logic      phase,
                                       input logic      evt_on);
        logic drive;
        case (mode)
            LED_OFF:   drive = 1'b0;
            LED_ON:    drive = 1'b1;
            LED_BLINK: drive = phase;
            LED_EVT:   drive = evt_on;
            default:   drive = 1'b0;
        endcase
        return drive;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Tick prescaler: a down-counter that pulses tick when it reaches zero and
// reloads from the divider. A divider write reloads the counter at once and
// swallows the tick of that cycle so the new rate starts cleanly.
module led_tick_gen
    import led_ctrl_pkg::*;
#(
    parameter logic [23:0] TICK_DIV_RST = 24'd999
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic [23:0] i_tick_div,
    input  logic        i_load,
    output logic        o_tick
);

    logic [23:0] r_cnt;

    // Zero count produces the tick unless a divider write is in progress
    assign o_tick = (r_cnt == 24'd0) && !i_load;

    // Prescaler counter: load on write, reload on zero, otherwise count down
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_cnt <= TICK_DIV_RST;
        end else if (i_load) begin
            r_cnt <= i_tick_div;
        end else if (r_cnt == 24'd0) begin
            r_cnt <= i_tick_div;
        end else begin
            r_cnt <= r_cnt - 24'd1;
        end
    end

endmodule

// File: rtl/led_ctrl.sv
// LED controller: APB register slave plus blink and event-stretch logic
// driving the three board LEDs. Each LED independently shows off, on, the
// shared blink phase, or a stretched version of its event strobe.
module led_ctrl
    import led_ctrl_pkg::*;
#(
    parameter logic [23:0] TICK_DIV_RST = 24'd999,
    parameter logic [7:0]  BLINK_RST    = 8'd10,
    parameter logic [7:0]  STRETCH      = 8'd5
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic        apb_psel,
    input  logic        apb_penable,
    input  logic        apb_pwrite,
    input  logic [3:0]  apb_paddr,
    input  logic [31:0] apb_pwdata,
    output logic [31:0] apb_prdata,
    output logic        apb_pready,
    input  logic [2:0]  evt,
    output logic        led0,
    output logic        led1,
    output logic        led2
);

    // Bus decode
    logic        w_access;
    logic        w_wr;
    logic        w_rd;
    logic [3:0]  w_addr;
    logic        w_wr_mode;
    logic        w_wr_tick;
    logic        w_wr_blink;
    logic        w_wr_status;
    logic [31:0] w_rdata;

    // Register state
    logic [5:0]  r_mode;
    logic [23:0] r_tick_div;
    logic [7:0]  r_blink;
    logic [2:0]  r_sticky;

    // Timing and event state
    logic        w_tick;
    logic [23:0] w_tick_div_val;
    logic [7:0]  r_bcnt;
    logic        r_phase;
    logic [2:0]  r_evt_d;
    logic [2:0]  w_edge;
    logic [2:0]  w_sticky_clr;
    logic [2:0]  w_stretch_on;
    logic [2:0]  w_led_nxt;
    logic [2:0]  r_led;

    // Write data bits that no register holds
    logic        w_unused;
    assign w_unused = ^{apb_paddr[1:0], apb_pwdata[31:24]};

    assign w_access    = apb_psel & apb_penable;
    assign w_wr        = w_access & apb_pwrite;
    assign w_rd        = w_access & ~apb_pwrite;
    assign w_addr      = {apb_paddr[3:2], 2'b00};
    assign w_wr_mode   = w_wr && (w_addr == ADDR_MODE);
    assign w_wr_tick   = w_wr && (w_addr == ADDR_TICK_DIV);
    assign w_wr_blink  = w_wr && (w_addr == ADDR_BLINK);
    assign w_wr_status = w_wr && (w_addr == ADDR_STATUS);

    // Control registers commit at the end of the APB access phase
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_mode     <= 6'd0;
            r_tick_div <= TICK_DIV_RST;
            r_blink    <= BLINK_RST;
        end else begin
            if (w_wr_mode) begin
                r_mode <= apb_pwdata[5:0];
            end
            if (w_wr_tick) begin
                r_tick_div <= apb_pwdata[23:0];
            end
            if (w_wr_blink) begin
                r_blink <= apb_pwdata[7:0];
            end
        end
    end

    // A divider write hands its new value straight to the prescaler
    assign w_tick_div_val = w_wr_tick ? apb_pwdata[23:0] : r_tick_div;

    led_tick_gen #(
        .TICK_DIV_RST (TICK_DIV_RST)
    ) u_tick_gen (
        .clk        (clk),
        .reset_     (reset_),
        .i_tick_div (w_tick_div_val),
        .i_load     (w_wr_tick),
        .o_tick     (w_tick)
    );

    // Shared blink phase; a BLINK write restarts it from phase 0
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_bcnt  <= 8'd0;
            r_phase <= 1'b0;
        end else if (w_wr_blink) begin
            r_bcnt  <= 8'd0;
            r_phase <= 1'b0;
        end else if (w_tick) begin
            if (r_bcnt == blink_last(r_blink)) begin
                r_bcnt  <= 8'd0;
                r_phase <= ~r_phase;
            end else begin
                r_bcnt <= r_bcnt + 8'd1;
            end
        end
    end

    // Delayed event copy for rising-edge detection
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_evt_d <= 3'b000;
        end else begin
            r_evt_d <= evt;
        end
    end

    assign w_edge       = evt & ~r_evt_d;
    assign w_sticky_clr = w_wr_status ? apb_pwdata[10:8] : 3'b000;

    // Sticky event flags: a new edge beats a simultaneous write-1-to-clear
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_sticky <= 3'b000;
        end else begin
            r_sticky <= (r_sticky & ~w_sticky_clr) | w_edge;
        end
    end

    // One stretch counter per LED; runs regardless of the LED's mode
    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_stretch
        logic [7:0] r_cnt;

        // Edge (re)loads the on-time, which then drains one step per tick
        always_ff @(posedge clk or negedge reset_) begin
            if (!reset_) begin
                r_cnt <= 8'd0;
            end else if (w_edge[g]) begin
                r_cnt <= STRETCH;
            end else if (w_tick && (r_cnt != 8'd0)) begin
                r_cnt <= r_cnt - 8'd1;
            end
        end

        assign w_stretch_on[g] = (r_cnt != 8'd0);
    end

    // Next LED values from each LED's mode field
    always_comb begin
        w_led_nxt = 3'b000;
        for (int n = 0; n < NUM_LEDS; n++) begin
            w_led_nxt[n] = led_drive(led_mode_e'(r_mode[2*n +: 2]), r_phase,
                                     w_stretch_on[n]);
        end
    end

    // Registered LED pins
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_led <= 3'b000;
        end else begin
            r_led <= w_led_nxt;
        end
    end

    assign led0 = r_led[0];
    assign led1 = r_led[1];
    assign led2 = r_led[2];

    // Read mux, only driven during a read access phase
    always_comb begin
        w_rdata = 32'd0;
        if (w_rd) begin
            case (w_addr)
                ADDR_MODE:     w_rdata = {26'd0, r_mode};
                ADDR_TICK_DIV: w_rdata = {8'd0, r_tick_div};
                ADDR_BLINK:    w_rdata = {24'd0, r_blink};
                ADDR_STATUS:   w_rdata = {21'd0, r_sticky, 5'd0, r_led};
                default:       w_rdata = 32'd0;
            endcase
        end else begin
            w_rdata = 32'd0;
        end
    end

    assign apb_prdata = w_rdata;
    assign apb_pready = 1'b1;

endmodule

// File: tb/tb_led_ctrl.sv
// Directed bench for led_ctrl. Stimulus pushes hand-computed expectations
// into two queues: LED values tagged with the cycle they must appear in, and
// read data for the next APB read. A monitor on the falling edge pops and
// compares them independently of the stimulus process.
module tb_led_ctrl;
    import led_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset_;
    logic        apb_psel;
    logic        apb_penable;
    logic        apb_pwrite;
    logic [3:0]  apb_paddr;
    logic [31:0] apb_pwdata;
    logic [31:0] apb_prdata;
    logic        apb_pready;
    logic [2:0]  evt;
    logic        led0;
    logic        led1;
    logic        led2;

    led_ctrl #(
        .TICK_DIV_RST (24'd3),
        .BLINK_RST    (8'd10),
        .STRETCH      (8'd5)
    ) dut (
        .clk         (clk),
        .reset_      (reset_),
        .apb_psel    (apb_psel),
        .apb_penable (apb_penable),
        .apb_pwrite  (apb_pwrite),
        .apb_paddr   (apb_paddr),
        .apb_pwdata  (apb_pwdata),
        .apb_prdata  (apb_prdata),
        .apb_pready  (apb_pready),
        .evt         (evt),
        .led0        (led0),
        .led1        (led1),
        .led2        (led2)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned at;
        logic [2:0]  leds;
        string       name;
    } led_exp_t;

    typedef struct {
        logic [31:0] data;
        string       name;
    } rd_exp_t;

    led_exp_t led_q[$];
    rd_exp_t  rd_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_leds(input int unsigned at, input logic [2:0] v,
                               input string name);
        led_exp_t e;
        e.at   = at;
        e.leds = v;
        e.name = name;
        led_q.push_back(e);
    endtask

    task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
        apb_psel    = 1'b1;
        apb_penable = 1'b0;
        apb_pwrite  = 1'b1;
        apb_paddr   = a;
        apb_pwdata  = d;
        step(1);
        apb_penable = 1'b1;
        step(1);
        apb_psel    = 1'b0;
        apb_penable = 1'b0;
        apb_pwrite  = 1'b0;
    endtask

    task automatic apb_read(input logic [3:0] a, input logic [31:0] exp,
                            input string name);
        rd_exp_t e;
        e.data = exp;
        e.name = name;
        rd_q.push_back(e);
        apb_psel    = 1'b1;
        apb_penable = 1'b0;
        apb_pwrite  = 1'b0;
        apb_paddr   = a;
        step(1);
        apb_penable = 1'b1;
        step(1);
        apb_psel    = 1'b0;
        apb_penable = 1'b0;
    endtask

    // Monitor: compare LED values due this cycle and any read data presented
    always @(negedge clk) begin
        for (int i = int'(led_q.size()) - 1; i >= 0; i--) begin
            if (led_q[i].at == cyc) begin
                check($sformatf("%s@%0d", led_q[i].name, led_q[i].at),
                      {29'd0, led2, led1, led0}, {29'd0, led_q[i].leds});
                led_q.delete(i);
            end else if (led_q[i].at < cyc) begin
                check($sformatf("%s_missed@%0d", led_q[i].name, led_q[i].at),
                      cyc, led_q[i].at);
                led_q.delete(i);
            end
        end
        if (apb_psel && apb_penable && !apb_pwrite) begin
            if (rd_q.size() == 0) begin
                check("unexpected_read", 32'd1, 32'd0);
            end else begin
                check(rd_q[0].name, apb_prdata, rd_q[0].data);
                void'(rd_q.pop_front());
            end
        end
    end

    initial begin
        int unsigned w;
        int unsigned wb;
        int unsigned c;
        int unsigned d;
        int unsigned s;
        int unsigned r;

        reset_      = 1'b0;
        apb_psel    = 1'b0;
        apb_penable = 1'b0;
        apb_pwrite  = 1'b0;
        apb_paddr   = 4'h0;
        apb_pwdata  = 32'd0;
        evt         = 3'b000;

        // Reset state, read while reset is still held
        step(2);
        check("rst_leds", {29'd0, led2, led1, led0}, 32'd0);
        check("rst_pready", {31'd0, apb_pready}, 32'd1);
        check("rst_prdata_idle", apb_prdata, 32'd0);
        apb_read(ADDR_MODE,     32'd0,  "rst_mode");
        apb_read(ADDR_TICK_DIV, 32'd3,  "rst_tick_div");
        apb_read(ADDR_BLINK,    32'd10, "rst_blink");
        apb_read(ADDR_STATUS,   32'd0,  "rst_status");
        reset_ = 1'b1;
        step(2);

        // All on, then all off: one cycle after each write commits
        apb_write(ADDR_MODE, 32'h15);
        w = cyc;
        expect_leds(w,     3'b000, "on_commit");
        expect_leds(w + 1, 3'b111, "on_next");
        apb_read(ADDR_MODE, 32'h15, "mode_rd");
        apb_read(4'h9, 32'h0A, "blink_rd_ignore_low_bits");
        step(1);
        apb_write(ADDR_MODE, 32'h00);
        w = cyc;
        expect_leds(w,     3'b111, "off_commit");
        expect_leds(w + 1, 3'b000, "off_next");
        step(2);

        // Blink: TICK_DIV=3, BLINK=2 -> toggle every 8, period 16
        apb_write(ADDR_TICK_DIV, 32'd3);
        apb_write(ADDR_BLINK, 32'd2);
        wb = cyc;
        apb_write(ADDR_MODE, 32'h2A);
        for (int k = 3; k <= 25; k++) begin
            expect_leds(wb + k, (k >= 7 && (((k - 7) / 8) % 2 == 0)) ? 3'b111 : 3'b000,
                        "blink");
        end
        step(21);
        // Rewrite BLINK while phase is 1: phase forced back to 0
        apb_write(ADDR_BLINK, 32'd2);
        for (int k = 26; k <= 40; k++) begin
            expect_leds(wb + k, (k >= 31 && k <= 38) ? 3'b111 : 3'b000, "blink_rst");
        end
        step(16);

        // Event stretch with a tick every cycle
        apb_write(ADDR_TICK_DIV, 32'd0);
        apb_write(ADDR_MODE, 32'h3F);
        c = cyc;
        expect_leds(c + 1, 3'b000, "evt1_pre");
        for (int k = 2; k <= 6; k++) begin
            expect_leds(c + k, 3'b010, "evt1_on");
        end
        expect_leds(c + 7, 3'b000, "evt1_off");
        evt = 3'b010;
        step(1);
        evt = 3'b000;
        apb_read(ADDR_STATUS, 32'h202, "status_evt1_led");
        step(5);
        apb_read(ADDR_STATUS, 32'h200, "status_evt1_flag");
        apb_write(ADDR_STATUS, 32'h200);
        apb_read(ADDR_STATUS, 32'h000, "status_w1c");

        // Retrigger evt[0] three ticks into the stretch: 3+5 cycles on
        d = cyc;
        expect_leds(d + 1, 3'b000, "retrig_pre");
        for (int k = 2; k <= 9; k++) begin
            expect_leds(d + k, 3'b001, "retrig_on");
        end
        expect_leds(d + 10, 3'b000, "retrig_off");
        evt = 3'b001;
        step(1);
        evt = 3'b000;
        step(2);
        evt = 3'b001;
        step(1);
        evt = 3'b000;
        step(7);

        // Edge and W1C of the same flag in one cycle: flag stays set
        s = cyc;
        fork
            apb_write(ADDR_STATUS, 32'h100);
            begin
                step(1);
                evt = 3'b001;
                step(1);
                evt = 3'b000;
            end
        join
        expect_leds(s + 2, 3'b000, "w1c_edge_pre");
        for (int k = 3; k <= 7; k++) begin
            expect_leds(s + k, 3'b001, "w1c_edge_on");
        end
        expect_leds(s + 8, 3'b000, "w1c_edge_off");
        apb_read(ADDR_STATUS, 32'h101, "status_set_wins");
        step(5);
        apb_write(ADDR_STATUS, 32'h100);
        apb_read(ADDR_STATUS, 32'h000, "status_w1c0");
        apb_read(4'h3, 32'h3F, "mode_rd_evt");

        // Fast blink, then asynchronous reset while LEDs are lit
        apb_write(ADDR_TICK_DIV, 32'd0);
        apb_write(ADDR_BLINK, 32'd1);
        wb = cyc;
        apb_write(ADDR_MODE, 32'h2A);
        for (int k = 3; k <= 7; k++) begin
            expect_leds(wb + k, (k % 2 == 0) ? 3'b111 : 3'b000, "fast_blink");
        end
        step(6);
        #2;
        check("pre_reset_leds", {29'd0, led2, led1, led0}, 32'h7);
        reset_ = 1'b0;
        #1;
        check("async_reset_leds", {29'd0, led2, led1, led0}, 32'd0);
        step(2);
        apb_read(ADDR_MODE,     32'd0,  "rst2_mode");
        apb_read(ADDR_TICK_DIV, 32'd3,  "rst2_tick_div");
        apb_read(ADDR_BLINK,    32'd10, "rst2_blink");
        apb_read(ADDR_STATUS,   32'd0,  "rst2_status");
        reset_ = 1'b1;

        // Fresh prescaler (reload 3): evt[2] stretch lasts 5 ticks of 4 cycles
        apb_write(ADDR_MODE, 32'h3F);
        r = cyc - 2;
        expect_leds(r + 3,  3'b000, "post_rst_pre");
        expect_leds(r + 4,  3'b100, "post_rst_on");
        expect_leds(r + 12, 3'b100, "post_rst_mid");
        expect_leds(r + 20, 3'b100, "post_rst_last");
        expect_leds(r + 21, 3'b000, "post_rst_off");
        evt = 3'b100;
        step(1);
        evt = 3'b000;
        step(20);
        apb_read(ADDR_STATUS, 32'h400, "post_rst_status");

        // Let outstanding expectations drain, bounded
        for (int i = 0; i < 200 && (led_q.size() != 0 || rd_q.size() != 0); i++) begin
            step(1);
        end
        check("drain_led_q", led_q.size(), 32'd0);
        check("drain_rd_q", rd_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/led_ctrl.md
# led_ctrl

LED controller that owns the three board LEDs (`led0`–`led2`) and shares them between firmware and hardware status sources. A small APB register slave lets the CPU set a mode per LED: off, on, blink, or event-stretch. A prescaled tick drives a common blink phase and per-LED event pulse stretchers. It sits between the CPU peripheral bus and the `Top` LED pins, replacing direct GPIO drive.

## Interface
Parameters:
- `TICK_DIV_RST`, default 24'd999, reset value of the tick prescaler reload.
- `BLINK_RST`, default 8'd10, reset value of the blink half-period, in ticks.
- `STRETCH`, default 8'd5, event on-time in ticks.

Ports:
- `clk` in 1: single clock; all logic is synchronous to it.
- `reset_` in 1: asynchronous, active-low reset.
- `apb_psel` in 1: APB select.
- `apb_penable` in 1: APB access phase.
- `apb_pwrite` in 1: 1 = write.
- `apb_paddr` in 4: byte address; bits [1:0] are ignored.
- `apb_pwdata` in 32: write data.
- `apb_prdata` out 32: read data, valid in the access phase.
- `apb_pready` out 1: tied to 1 (no wait states).
- `evt` in 3: per-LED event strobes, synchronous to `clk`, level or pulse.
- `led0`, `led1`, `led2` out 1: LED drive, active-high, registered.

## Operation
Registers:
- 0x0 MODE (RW, [5:0]): 2 bits per LED, with LED n at [2n+1:2n]. Encoding: 0 off, 1 on, 2 blink, 3 event. Reset value 0.
- 0x4 TICK_DIV (RW, [23:0]): the prescaler reloads to this value.
- 0x8 BLINK (RW, [7:0]): blink half-period in ticks. A value of 0 behaves as 1.
- 0xC STATUS: [2:0] current LED values (RO); [10:8] sticky event flags (W1C). Reset value 0.
- Unmapped reads return 0; unmapped writes are ignored.

Tick generator:
- Down-counter `cnt`. When `cnt==0` it asserts `tick` for one cycle and reloads from TICK_DIV; otherwise it decrements.
- TICK_DIV=0 gives `tick` every cycle.

Blink:
- A shared counter `bcnt` advances on `tick`.
- When `bcnt==max(BLINK,1)-1`, `bcnt` clears to 0 and `phase` toggles.
- All LEDs in blink mode show `phase`, so they are in phase with each other.

Event:
- A rising edge is detected as `evt & ~evt_d`.
- On an edge, LED n's stretch counter loads `STRETCH` and STATUS bit 8+n sets.
- The counter decrements on `tick` while nonzero. The event-mode LED is on while the counter is nonzero.
- The counter runs in every mode; only the output depends on the mode.

Boundary rules:
- Edge and `tick` in the same cycle: the load wins.
- Retrigger while the counter is nonzero: the counter reloads to `STRETCH`.
- Sticky flag set and W1C write in the same cycle: set wins.
- Write to TICK_DIV: `cnt` loads the new value immediately; no `tick` is generated that cycle.
- Write to BLINK: `bcnt` clears to 0 and `phase` clears to 0.
- Write to MODE: the blink phase and stretch counters are unaffected.
- Reset asserted mid-operation: everything returns to reset values asynchronously.

## Timing
- A write commits on the clock edge at the end of the access phase (`psel & penable & pwrite`).
- LEDs reflect a new MODE on the following edge, i.e. 1 cycle after the write commits.
- `apb_prdata` is combinational from the register state during the access phase.
- Event to LED on: 2 cycles from `evt` rising at an edge (edge register, then output register).
- LED output changes 1 cycle after the `tick` that causes them.
- Blink period is `2·max(BLINK,1)·(TICK_DIV+1)` cycles.
- Values at reset:
  - `cnt`=`TICK_DIV_RST`, `bcnt`=0, `phase`=0.
  - Stretch counters=0, `evt_d`=0.
  - `led0`–`led2`=0.
  - `apb_prdata`=0, `apb_pready`=1.

## Structure
- Package `led_ctrl_pkg`:
  - Register address constants `ADDR_MODE`, `ADDR_TICK_DIV`, `ADDR_BLINK`, `ADDR_STATUS`.
  - 2-bit mode enum `LED_OFF`, `LED_ON`, `LED_BLINK`, `LED_EVT`.
- Sub-module `led_tick_gen` contains the prescaler: inputs `TICK_DIV`, the load strobe, `clk` and `reset_`; output `tick`.
- The stretch counters are a 3-instance generate loop inside `led_ctrl`.

## Test plan
- Reset: with `reset_` held low, all LEDs are 0 and all registers read back their reset values. `TICK_DIV_RST=3` is used in the directed tests.
- Write MODE=0x15 (all on): LEDs go to 1 exactly 1 cycle after the write. Then write 0x00: LEDs go to 0.
- TICK_DIV=3, BLINK=2, MODE=0x2A: all three LEDs toggle together every 8 cycles, with a period of 16. Writing BLINK mid-period forces `phase`=0 on the next edge.
- TICK_DIV=0, STRETCH=5, MODE=0x3F, 1-cycle pulse on `evt[1]`: `led1` is high for exactly 5 cycles starting 2 cycles after the pulse, and STATUS reads 0x200 \| LED bits. Writing STATUS=0x200 clears the flag.
- Retrigger `evt[0]` 3 ticks into a stretch: on-time extends to 3+5 ticks. An edge coinciding with a W1C write leaves the flag set.
- Pulse `reset_` low mid-blink: LEDs drop to 0 asynchronously, with no clock required. After release, behaviour matches a fresh reset.
